// File: rtl/div_recombine_if.sv
// Handshake/operand bundle for div_recombine.
// With DIV_RECOMBINE_CHECK_EN defined the bundle also carries the err flag.
interface div_recombine_if #(parameter int WIDTH = 4);
  logic               start;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   d;
  logic [WIDTH:0]     r;
  logic               busy;
  logic               done;
  logic [2*WIDTH:0]   p;
`ifdef DIV_RECOMBINE_CHECK_EN
  logic               err;
  modport master (output start, q, d, r, input busy, done, p, err);
  modport slave  (input start, q, d, r, output busy, done, p, err);
`else
  modport master (output start, q, d, r, input busy, done, p);
  modport slave  (input start, q, d, r, output busy, done, p);
`endif
endinterface

// File: rtl/div_recombine.sv
// div_recombine: sequential shift-add p = q*d + r, one iteration per clock.
// Inverse of the non-restoring divider (WIDTH-bit q/d, WIDTH+1-bit r).
// Optional feature macro: DIV_RECOMBINE_CHECK_EN adds err, flagging triples
// the divider could never have produced.
module div_recombine #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  div_recombine_if.slave bus
);
  localparam int P_W = 2*WIDTH + 1;
  localparam int C_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] mq;
  logic [P_W-1:0]   md;
  logic [P_W-1:0]   acc;
  logic [C_W-1:0]   cnt;
  logic [P_W-1:0]   acc_next;
  logic             last;

`ifdef DIV_RECOMBINE_CHECK_EN
  // md shifts away, so the original divisor and remainder are kept for the check
  logic [WIDTH-1:0] d_lat;
  logic [WIDTH:0]   r_lat;
  logic             bad_triple;
`endif

  // next accumulator value and final-iteration detect
  always_comb begin
    acc_next = acc + (mq[0] ? md : '0);
    last     = (cnt == C_W'(WIDTH-1));
  end

`ifdef DIV_RECOMBINE_CHECK_EN
  // illegal divider output: zero divisor, remainder too big, or dividend overflows WIDTH bits
  always_comb begin
    bad_triple = (d_lat == '0) || ({1'b0, r_lat} >= {2'b0, d_lat}) ||
                 (acc_next[P_W-1:WIDTH] != '0);
  end
`endif

  // control FSM and datapath with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mq       <= '0;
      md       <= '0;
      acc      <= '0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.p    <= '0;
`ifdef DIV_RECOMBINE_CHECK_EN
      d_lat    <= '0;
      r_lat    <= '0;
      bus.err  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            mq       <= bus.q;
            md       <= {{(P_W-WIDTH){1'b0}}, bus.d};
            acc      <= {{(P_W-WIDTH-1){1'b0}}, bus.r};
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
`ifdef DIV_RECOMBINE_CHECK_EN
            d_lat    <= bus.d;
            r_lat    <= bus.r;
`endif
          end
        end
        RUN: begin
          acc <= acc_next;
          md  <= md << 1;
          mq  <= mq >> 1;
          cnt <= cnt + 1'b1;
          if (last) begin
            bus.p    <= acc_next;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= DONE;
`ifdef DIV_RECOMBINE_CHECK_EN
            bus.err  <= bad_triple;
`endif
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_recombine.sv
// Self-checking bench for div_recombine (WIDTH=4): directed table, hand-written
// multi-cycle sequences, and random operands against an arithmetic model.
module tb_div_recombine;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  div_recombine_if #(.WIDTH(W)) bus ();
  div_recombine #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] d;
    logic [W:0]   r;
    logic [2*W:0] ep;
    logic         ee;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // reference: plain arithmetic on the triple
  function automatic logic [2*W:0] model_p(input int q, input int d, input int r);
    return (2*W+1)'(q*d + r);
  endfunction
  function automatic logic model_err(input int q, input int d, input int r);
    return (d == 0) || (r >= d) || (q*d + r >= (1 << W));
  endfunction

  // one operation: start for one cycle, optionally scramble inputs while busy,
  // check p holds its old value until done, latency, p, err, and done pulse width
  task automatic run_op(input string nm, input logic [W-1:0] q, input logic [W-1:0] d,
                        input logic [W:0] r, input logic [2*W:0] ep, input logic ee,
                        input bit scramble);
    logic [2*W:0] p_old;
    int n;
    @(negedge clk);
    p_old = bus.p;
    bus.start = 1'b1; bus.q = q; bus.d = d; bus.r = r;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({nm, ".busy"}, 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.done && n < 20) begin
      if (scramble) begin
        bus.q = W'($urandom); bus.d = W'($urandom); bus.r = (W+1)'($urandom);
      end
      if (n > 0) chk({nm, ".p_hold"}, 32'(bus.p), 32'(p_old));
      @(posedge clk); #1;
      n++;
    end
    chk({nm, ".lat"}, 32'(n), 32'(W));
    chk({nm, ".p"}, 32'(bus.p), 32'(ep));
    chk({nm, ".busy_end"}, 32'(bus.busy), 32'd0);
`ifdef DIV_RECOMBINE_CHECK_EN
    chk({nm, ".err"}, 32'(bus.err), 32'(ee));
`else
    if (ee) begin end
`endif
    @(posedge clk); #1;
    chk({nm, ".done_off"}, 32'(bus.done), 32'd0);
    chk({nm, ".p_after"}, 32'(bus.p), 32'(ep));
  endtask

  vec_t tbl[6];

  initial begin
    int dones;
    bus.start = 1'b0; bus.q = '0; bus.d = '0; bus.r = '0;

    tbl[0] = '{q:4'd4,  d:4'd3,  r:5'd2,  ep:9'd14,  ee:1'b0};
    tbl[1] = '{q:4'd15, d:4'd15, r:5'd16, ep:9'd241, ee:1'b1};
    tbl[2] = '{q:4'd0,  d:4'd0,  r:5'd5,  ep:9'd5,   ee:1'b1};
    tbl[3] = '{q:4'd2,  d:4'd5,  r:5'd1,  ep:9'd11,  ee:1'b0};
    tbl[4] = '{q:4'd3,  d:4'd4,  r:5'd0,  ep:9'd12,  ee:1'b0};
    tbl[5] = '{q:4'd1,  d:4'd15, r:5'd0,  ep:9'd15,  ee:1'b0};

    #12;
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.p", 32'(bus.p), 32'd0);
`ifdef DIV_RECOMBINE_CHECK_EN
    chk("rst.err", 32'(bus.err), 32'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_op($sformatf("tbl%0d", i), tbl[i].q, tbl[i].d, tbl[i].r, tbl[i].ep, tbl[i].ee, 1'b0);

    // back-to-back with inputs scrambled while busy; p holds 11 until second done
    run_op("b2b0", 4'd2, 4'd5, 5'd1, 9'd11, 1'b0, 1'b1);
    run_op("b2b1", 4'd3, 4'd4, 5'd0, 9'd12, 1'b0, 1'b1);

    // start held high: accepts only every W+2 cycles
    @(negedge clk);
    bus.start = 1'b1; bus.q = 4'd0; bus.d = 4'd0; bus.r = 5'd5;
    dones = 0;
    for (int k = 0; k < 3*(W+2); k++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    chk("cont.dones", 32'(dones), 32'd3);
    chk("cont.p", 32'(bus.p), 32'd5);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (W+3) @(posedge clk);
    #1;

    // reset during 2nd iteration aborts; no done afterwards
    @(negedge clk);
    bus.start = 1'b1; bus.q = 4'd7; bus.d = 4'd7; bus.r = 5'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst.busy", 32'(bus.busy), 32'd0);
    chk("arst.done", 32'(bus.done), 32'd0);
    chk("arst.p", 32'(bus.p), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < W+4; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) dones++;
    end
    chk("arst.no_done", 32'(dones), 32'd0);
    run_op("post_rst", 4'd7, 4'd7, 5'd0, 9'd49, 1'b1, 1'b0);

    // random operands against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      int rq, rd, rr;
      rq = int'($urandom_range(0, (1 << W) - 1));
      rd = int'($urandom_range(0, (1 << W) - 1));
      rr = int'($urandom_range(0, (1 << (W+1)) - 1));
      run_op($sformatf("rnd%0d", i), W'(rq), W'(rd), (W+1)'(rr),
             model_p(rq, rd, rr), model_err(rq, rd, rr), i[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 want=1");
    $fatal(1);
  end
endmodule
